plab1_imul_req_queue: RTL

//   Request buffer that sits directly upstream of the variable-latency

---
 rtl/plab1_imul_req_queue.sv | 91 +++++++++
 1 files changed

// File: rtl/plab1_imul_req_queue.sv
// Request queue in front of the iterative integer multiplier.
// Circular FIFO with val/rdy on both sides and a gated head output.
module plab1_imul_req_queue #(
  parameter int p_nbits       = 67,
  parameter int p_num_entries = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             domain,
  input  logic                             flush,
  input  logic                             in_val,
  output logic                             in_rdy,
  input  logic [p_nbits-1:0]               in_msg,
  output logic                             out_val,
  input  logic                             out_rdy,
  output logic [p_nbits-1:0]               out_msg,
  output logic [$clog2(p_num_entries):0]   num_free_entries
);

  localparam int ptr_w = $clog2(p_num_entries);
  localparam int cnt_w = ptr_w + 1;

  localparam logic [cnt_w-1:0] depth_c = cnt_w'(p_num_entries);
  localparam logic [ptr_w-1:0] ptr_one = ptr_w'(1);
  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

  logic [ptr_w-1:0] enq_ptr;
  logic [ptr_w-1:0] deq_ptr;
  logic [cnt_w-1:0] count;

  logic [p_nbits-1:0] mem [p_num_entries];

  logic full;
  logic empty;
  logic enq_go;
  logic deq_go;

  // The label travels with the data; the queue itself never
  // inspects it, since every entry belongs to the current domain.
  logic domain_unused;
  assign domain_unused = domain;

  assign full  = (count == depth_c);
  assign empty = (count == '0);

  // Handshake outputs come from registered state plus flush/reset
  // only, so there is no in->out or out_rdy->in_rdy path.
  always_comb begin
    in_rdy  = !reset && !full && !flush;
    out_val = !empty && !flush;
  end

  assign enq_go = in_val && in_rdy;
  assign deq_go = out_val && out_rdy;

  // Head data is zeroed whenever it is not valid so stale
  // entries never appear on the multiplier input.
  always_comb begin
    out_msg = '0;
    if (out_val) out_msg = mem[deq_ptr];
  end

  assign num_free_entries = depth_c - count;

  // Pointer and occupancy state; flush clears it like a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else if (flush) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else begin
      if (enq_go) enq_ptr <= enq_ptr + ptr_one;
      if (deq_go) deq_ptr <= deq_ptr + ptr_one;
      unique case ({enq_go, deq_go})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
    end
  end

  // Storage holds no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (enq_go) mem[enq_ptr] <= in_msg;
  end

endmodule
